// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit common-anode 7-segment scan driver:
// active-low glyphs (dp bit held off), anode idle pattern and scan states.
package seg7_pkg;

  // Glyphs are active low, bit order {dp, g, f, e, d, c, b, a}; dp kept off here.
  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;
  localparam logic [7:0] SEG_A   = 8'h88;
  localparam logic [7:0] SEG_B   = 8'h83;
  localparam logic [7:0] SEG_C   = 8'hC6;
  localparam logic [7:0] SEG_D   = 8'hA1;
  localparam logic [7:0] SEG_E   = 8'h86;
  localparam logic [7:0] SEG_F   = 8'h8E;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // All anodes released (active-low drive).
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Each digit slot is a short dark gap followed by the lit interval.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-low 7-segment glyph (segments g..a only).
module seg7_hex_decode (
  input  logic [3:0] i_val,
  output logic [6:0] o_glyph
);

  import seg7_pkg::*;

  // Glyph lookup; the decimal point is merged by the caller.
  always_comb begin
    o_glyph = SEG_OFF[6:0];
    case (i_val)
      4'h0:    o_glyph = SEG_0[6:0];
      4'h1:    o_glyph = SEG_1[6:0];
      4'h2:    o_glyph = SEG_2[6:0];
      4'h3:    o_glyph = SEG_3[6:0];
      4'h4:    o_glyph = SEG_4[6:0];
      4'h5:    o_glyph = SEG_5[6:0];
      4'h6:    o_glyph = SEG_6[6:0];
      4'h7:    o_glyph = SEG_7[6:0];
      4'h8:    o_glyph = SEG_8[6:0];
      4'h9:    o_glyph = SEG_9[6:0];
      4'hA:    o_glyph = SEG_A[6:0];
      4'hB:    o_glyph = SEG_B[6:0];
      4'hC:    o_glyph = SEG_C[6:0];
      4'hD:    o_glyph = SEG_D[6:0];
      4'hE:    o_glyph = SEG_E[6:0];
      4'hF:    o_glyph = SEG_F[6:0];
      default: o_glyph = SEG_OFF[6:0];
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// New digit data is staged in a pending register and only copied into the
// displayed register at a frame boundary, so a frame never mixes old and new
// values. Each slot starts with a dark gap to hide anode/segment ghosting.
module seg7_scan_mux #(
  parameter int DIGIT_CYCLES = 20000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  en_in,
  input  logic        lz_sup,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done,
  output logic        upd_ack
);

  import seg7_pkg::*;

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  scan_state_t   r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [1:0]    r_idx, w_idx_next;

  logic [15:0]   r_pend_digits, r_disp_digits;
  logic [3:0]    r_pend_dp, r_pend_en, r_disp_dp, r_disp_en;
  logic          r_pend_lz, r_disp_lz, r_pend_vld;

  logic [3:0]    r_an;
  logic [7:0]    r_seg;
  logic          r_frame_done, r_upd_ack;

  logic          w_wrap, w_commit;
  logic [3:0]    w_zod, w_sup;
  logic [3:0]    w_cur_val;
  logic [6:0]    w_glyph;
  logic [3:0]    w_an_next;
  logic [7:0]    w_seg_next;

  // The frame ends on the last lit cycle of digit3; pending data is committed
  // there, or straight away while scanning is disabled.
  assign w_wrap   = enable && (r_state == ST_ON) && (r_cnt == CNT_LAST) && (r_idx == 2'd3);
  assign w_commit = r_pend_vld && (w_wrap || !enable);

  // Scan position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  // Slot counter, digit index and BLANK/ON sequencing; disable parks at digit0 BLANK.
  always_comb begin
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_state_next = r_state;
    if (!enable) begin
      w_cnt_next   = '0;
      w_idx_next   = 2'd0;
      w_state_next = ST_BLANK;
    end else begin
      if (r_cnt == CNT_LAST) begin
        w_cnt_next = '0;
        w_idx_next = r_idx + 2'd1;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
      case (r_state)
        ST_BLANK: if (w_cnt_next >= CNT_BLANK) w_state_next = ST_ON;
        ST_ON:    if ((r_cnt == CNT_LAST) && (CNT_BLANK != '0)) w_state_next = ST_BLANK;
        default:  w_state_next = ST_BLANK;
      endcase
    end
  end

  // Pending/display registers: a load landing on a commit cycle stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_vld    <= 1'b0;
      r_pend_digits <= '0;
      r_pend_dp     <= '0;
      r_pend_en     <= '0;
      r_pend_lz     <= 1'b0;
      r_disp_digits <= '0;
      r_disp_dp     <= '0;
      r_disp_en     <= '0;
      r_disp_lz     <= 1'b0;
      r_upd_ack     <= 1'b0;
    end else begin
      if (w_commit) begin
        r_disp_digits <= r_pend_digits;
        r_disp_dp     <= r_pend_dp;
        r_disp_en     <= r_pend_en;
        r_disp_lz     <= r_pend_lz;
      end
      if (load) begin
        r_pend_digits <= digits;
        r_pend_dp     <= dp_in;
        r_pend_en     <= en_in;
        r_pend_lz     <= lz_sup;
        r_pend_vld    <= 1'b1;
      end else if (w_commit) begin
        r_pend_vld    <= 1'b0;
      end
      r_upd_ack <= w_commit;
    end
  end

  // Leading-zero suppression: a zero digit goes dark when every digit to its
  // left is zero or disabled. Digit0 always shows.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign w_zod[gi] = (r_disp_digits[gi*4 +: 4] == 4'd0) || !r_disp_en[gi];
    if (gi == 0) begin : g_lsd
      assign w_sup[gi] = 1'b0;
    end else begin : g_hi
      localparam logic [3:0] HI_MASK = 4'(4'hF << (gi + 1));
      assign w_sup[gi] = r_disp_lz && (r_disp_digits[gi*4 +: 4] == 4'd0) &&
                         (&(w_zod | ~HI_MASK));
    end
  end

  assign w_cur_val = r_disp_digits[{r_idx, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .i_val   (w_cur_val),
    .o_glyph (w_glyph)
  );

  // Next anode/segment pattern; dark digits keep their anode so brightness is even.
  always_comb begin
    w_an_next  = AN_OFF;
    w_seg_next = SEG_OFF;
    if (enable && (r_state == ST_ON)) begin
      w_an_next = ~(4'b0001 << r_idx);
      if (!r_disp_en[r_idx]) begin
        w_seg_next = SEG_OFF;
      end else if (w_sup[r_idx]) begin
        w_seg_next = {~r_disp_dp[r_idx], 7'h7F};
      end else begin
        w_seg_next = {~r_disp_dp[r_idx], w_glyph};
      end
    end
  end

  // Registered display outputs and frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an         <= AN_OFF;
      r_seg        <= SEG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_next;
      r_seg        <= w_seg_next;
      r_frame_done <= w_wrap;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;
  assign upd_ack    = r_upd_ack;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux with short slots. The reference model tracks the
// scan as elapsed enabled cycles: slot = t / D, digit = slot mod 4, and a slot
// is dark for its first B cycles. Every cycle all four outputs are compared.
module tb_seg7_scan_mux;

  localparam int D     = 8;
  localparam int B     = 2;
  localparam int FRAME = 4 * D;

  logic        clk = 1'b0;
  logic        rst, enable, load, lz_sup;
  logic [15:0] digits;
  logic [3:0]  dp_in, en_in;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_done, upd_ack;

  always #5 clk = ~clk;

  seg7_scan_mux #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .digits     (digits),
    .dp_in      (dp_in),
    .en_in      (en_in),
    .lz_sup     (lz_sup),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done),
    .upd_ack    (upd_ack)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int          m_s;
  bit          m_pv;
  logic [15:0] m_pd, m_dd;
  logic [3:0]  m_pdp, m_ddp, m_pen, m_den;
  logic        m_plz, m_dlz;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;
  logic        e_fd, e_ack;
  int          ack_count, fd_count;
  logic [7:0]  glyph [16];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Segment pattern the spec rules require for a lit digit slot.
  function automatic logic [7:0] lit_seg(input int idx);
    logic [3:0] v;
    logic       sup;
    logic       dpb;
    v = m_dd[idx*4 +: 4];
    if (!m_den[idx]) return 8'hFF;
    dpb = ~m_ddp[idx];
    sup = m_dlz && (idx > 0) && (v == 4'd0);
    for (int j = idx + 1; j < 4; j++)
      if ((m_dd[j*4 +: 4] != 4'd0) && m_den[j]) sup = 1'b0;
    if (sup) return {dpb, 7'h7F};
    return {dpb, glyph[v][6:0]};
  endfunction

  // One clock: advance the model with the inputs sampled at this edge, then check.
  task automatic tick();
    int  idx;
    bit  wrap, commit;
    @(posedge clk);
    if (rst) begin
      m_s = 0; m_pv = 0; m_den = 4'h0; m_dd = 16'h0; m_ddp = 4'h0; m_dlz = 1'b0;
      e_an = 4'hF; e_seg = 8'hFF; e_fd = 1'b0; e_ack = 1'b0;
    end else begin
      wrap = enable && ((m_s % FRAME) == FRAME - 1);
      if (enable && ((m_s % D) >= B)) begin
        idx   = (m_s / D) % 4;
        e_an  = 4'hF & ~(4'(1) << idx);
        e_seg = lit_seg(idx);
      end else begin
        e_an  = 4'hF;
        e_seg = 8'hFF;
      end
      commit = m_pv && (wrap || !enable);
      e_fd   = wrap;
      e_ack  = commit;
      if (commit) begin
        m_dd = m_pd; m_ddp = m_pdp; m_den = m_pen; m_dlz = m_plz;
      end
      if (load) begin
        m_pd = digits; m_pdp = dp_in; m_pen = en_in; m_plz = lz_sup; m_pv = 1;
      end else if (commit) begin
        m_pv = 0;
      end
      m_s = enable ? m_s + 1 : 0;
    end
    #1;
    chk("an", {4'h0, an}, {4'h0, e_an});
    chk("seg", seg, e_seg);
    chk("frame_done", {7'h0, frame_done}, {7'h0, e_fd});
    chk("upd_ack", {7'h0, upd_ack}, {7'h0, e_ack});
    if (upd_ack === 1'b1) ack_count++;
    if (frame_done === 1'b1) fd_count++;
  endtask

  // Advance until the next edge will sample scan position 'pos' within a frame.
  task automatic align(input int pos);
    for (int k = 0; k <= FRAME; k++) begin
      if ((m_s % FRAME) == pos) break;
      tick();
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                         input logic lz);
    digits = d; dp_in = dp; en_in = en; lz_sup = lz; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    glyph = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    ack_count = 0; fd_count = 0;
    m_s = 0; m_pv = 0; m_pd = '0; m_pdp = '0; m_pen = '0; m_plz = 1'b0;
    m_dd = '0; m_ddp = '0; m_den = '0; m_dlz = 1'b0;
    rst = 1'b1; enable = 1'b0; load = 1'b0; lz_sup = 1'b0;
    digits = 16'h0; dp_in = 4'h0; en_in = 4'h0;
    repeat (3) tick();
    chk("reset_an", {4'h0, an}, 8'h0F);
    chk("reset_seg", seg, 8'hFF);
    rst = 1'b0;

    // 1: basic scan of 1234.
    enable = 1'b1;
    ack_count = 0;
    do_load(16'h1234, 4'h0, 4'hF, 1'b0);
    repeat (FRAME + 8) tick();
    align(5);
    tick();
    chk("t1_digit0_an", {4'h0, an}, 8'h0E);
    chk("t1_digit0_seg", seg, 8'h99);
    align(3 * D + 4);
    tick();
    chk("t1_digit3_seg", seg, 8'hF9);
    fd_count = 0;
    repeat (2 * FRAME) tick();
    chk("t1_ack_once", 8'(ack_count), 8'd1);
    chk("t1_fd_per_frame", 8'(fd_count), 8'd2);

    // 2: leading-zero suppression on and off.
    do_load(16'h0009, 4'h0, 4'hF, 1'b1);
    repeat (2 * FRAME) tick();
    align(2 * D + 4);
    tick();
    chk("t2_sup_seg", seg, 8'hFF);
    chk("t2_sup_an", {4'h0, an}, 8'h0B);
    do_load(16'h0009, 4'h0, 4'hF, 1'b0);
    repeat (2 * FRAME) tick();
    align(2 * D + 4);
    tick();
    chk("t2_nosup_seg", seg, 8'hC0);

    // 3: load at digit1; commit lands on the frame boundary.
    align(D + 3);
    do_load(16'h1111, 4'h0, 4'hF, 1'b0);
    align(FRAME - 1);
    tick();
    chk("t3_fd", {7'h0, frame_done}, 8'h01);
    chk("t3_ack", {7'h0, upd_ack}, 8'h01);
    repeat (FRAME) tick();

    // 4: two loads in one frame, second wins, one ack.
    align(5);
    ack_count = 0;
    do_load(16'(($urandom)), 4'($urandom), 4'hF, 1'($urandom));
    repeat (2) tick();
    do_load(16'hABCD, 4'h5, 4'hF, 1'b0);
    repeat (2 * FRAME) tick();
    chk("t4_ack_once", 8'(ack_count), 8'd1);

    // 5: enable drop during digit2 ON, then restart.
    align(2 * D + 4);
    tick();
    chk("t5_lit_an", {4'h0, an}, 8'h0B);
    enable = 1'b0;
    tick();
    chk("t5_off_an", {4'h0, an}, 8'h0F);
    chk("t5_off_seg", seg, 8'hFF);
    repeat (3) tick();
    enable = 1'b1;
    repeat (2) tick();
    chk("t5_blank_an", {4'h0, an}, 8'h0F);
    tick();
    chk("t5_restart_an", {4'h0, an}, 8'h0E);
    repeat (FRAME) tick();

    // 6: reset with a load pending.
    align(D + 4);
    do_load(16'h5678, 4'hF, 4'hF, 1'b0);
    rst = 1'b1;
    tick();
    chk("t6_rst_an", {4'h0, an}, 8'h0F);
    chk("t6_rst_seg", seg, 8'hFF);
    rst = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick();
      chk("t6_dark_seg", seg, 8'hFF);
    end

    // Random traffic: loads, occasional enable toggles.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 9) == 0) begin
        digits = 16'($urandom); dp_in = 4'($urandom);
        en_in = 4'($urandom); lz_sup = 1'($urandom);
        if ($urandom_range(0, 1) == 0) digits[15:8] = 8'h00;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
Downstream display stage for the traffic-light controller. It takes four BCD/hex digit values plus per-digit enables and decimal points, and time-multiplexes them onto the Spartan-3E 4-digit common-anode 7-segment display. It adds tear-free frame-synchronous updates, an inter-digit blanking gap against ghosting, leading-zero suppression and a global display enable. This replaces the ad-hoc divider/anode logic in the light FSM, which becomes a pure producer of countdown digits.

Parameters:
DIGIT_CYCLES, 20000, clk cycles per digit slot (400 us at 50 MHz); must be > BLANK_CYCLES.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; 0 disables blanking.

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous, active-high reset
enable  in  1  1 = scan display; 0 = all anodes off
load  in  1  1-cycle strobe: capture digits/dp_in/en_in/lz_sup into pending register
digits  in  16  four 4-bit values; [3:0] = digit0 (rightmost) … [15:12] = digit3
dp_in  in  4  decimal point per digit, 1 = lit
en_in  in  4  per-digit enable, 1 = shown
lz_sup  in  1  1 = suppress leading zeros
an  out  4  anode drive, active low, one-hot-low when lit
seg  out  8  segments, active low; [6:0] = g..a, [7] = dp
frame_done  out  1  1-cycle pulse at the end of the digit3 slot
upd_ack  out  1  1-cycle pulse when pending data is committed to the display register

Behaviour:
- One clock; reset is synchronous and active-high. Clock is clk, reset is rst.
- Reset values:
  - an=4'b1111, seg=8'hFF, frame_done=0, upd_ack=0.
  - Slot counter 0, digit index 0, state BLANK.
  - Pending-valid flag 0; display register all en=0.
- Load handshake:
  - load=1 overwrites pending and sets pending-valid; back-to-back loads are allowed and the last one wins.
  - Commit occurs in the cycle the index wraps 3->0 (frame boundary), or immediately if enable=0.
  - Commit copies pending into the display register, clears pending-valid and pulses upd_ack the following cycle.
  - A load in the same cycle as a commit is captured into pending and committed at the next boundary; the prior pending data is the data committed.
- FSM, two states per slot:
  - BLANK: an=1111, seg=FF, for BLANK_CYCLES cycles (skipped when 0).
  - ON: for DIGIT_CYCLES-BLANK_CYCLES cycles.
  - At the last ON cycle the counter resets to 0, the index increments mod 4 and the state returns to BLANK.
  - frame_done pulses in the cycle the index wraps from 3 to 0.
- Output in ON:
  - an bit[index]=0, all others 1; seg = decode(digit[index]) with seg[7]=~dp[index].
  - A digit that is disabled or suppressed keeps its anode low but drives seg=8'hFF, so brightness stays uniform.
- Decode: 0-9 standard; A-F hex glyphs (A,b,C,d,E,F).
- Leading-zero suppression (lz_sup=1):
  - digit k (k=3..1) is blanked if its value is 0 and every higher digit is 0 or disabled.
  - digit0 is never suppressed.
  - dp still shows on a suppressed digit.
- Outputs are registered: an and seg change in the same cycle, one cycle after the state/index update.
- Enable rules:
  - enable 1->0: next cycle an=1111, seg=FF, counter=0, index=0, state BLANK, no frame_done.
  - enable 0->1: scan restarts at digit0 BLANK.
- rst mid-frame: all state returns to reset values next cycle and pending data is discarded.

Decomposition:
- Package seg7_pkg: segment glyph constants (SEG_0..SEG_F, SEG_OFF=8'hFF), AN_OFF=4'b1111, state encoding (ST_BLANK, ST_ON).
- Sub-module seg7_hex_decode: combinational 4-bit -> 7-segment active-low glyph lookup.
- Slot timing, FSM, suppression and load/commit logic stay in seg7_scan_mux.

Test Plan:
Use DIGIT_CYCLES=8, BLANK_CYCLES=2 throughout.
1. Reset, then enable=1 and load digits=16'h1234, en_in=F, dp_in=0 -> upd_ack pulses once. From the next frame an cycles 1110,1101,1011,0111, each 6 cycles lit after 2 blank; seg = 4, 3, 2, 1 glyphs (4 -> 8'h99, 1 -> 8'hF9); frame_done every 32 cycles.
2. Load 16'h0009 with lz_sup=1, en_in=F -> digits 3..1 show seg=FF with anode pulsing; digit0 shows 8'h90. Repeat with lz_sup=0 -> digits 3..1 show 8'hC0.
3. Load 16'h1111 mid-frame at digit1 -> digit2/3 still show the old values; the new value appears from the next digit0; upd_ack is coincident with the frame boundary.
4. Two loads 3 cycles apart within one frame -> only the second is displayed; exactly one upd_ack.
5. Deassert enable during digit2 ON -> next cycle an=1111, seg=FF. Reassert -> digit0 BLANK for 2 cycles, then digit0 ON.
6. Assert rst during digit1 ON with a load pending -> an=1111, seg=FF next cycle. The pending data is never shown; the display stays blank until a new load.
